seq_adder_nbit: RTL and testbench

//   Parametrised multi-cycle add/subtract unit; next generation of the 2-bit ripple adder.

---
 rtl/seq_adder_nbit_pkg.sv | 16 +
 rtl/seq_adder_nbit_chunk.sv | 42 ++++
 rtl/seq_adder_nbit.sv | 126 ++++++++++++
 tb/tb_seq_adder_nbit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_nbit_pkg.sv
// Shared types and helpers for the chunked sequential add/subtract unit.
// State encoding is fixed at 2 bits so the FSM matches the adder family's register map.
package seq_adder_nbit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width for NCHUNK chunks; a single-chunk build still needs a 1-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_nbit_chunk.sv
// N-bit ripple-carry slice built from full-adder cells; purely combinational.
// The top reuses one instance of this slice for every chunk of the operands.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module adder_chunk #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] carry;

  assign carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      full_adder u_fa (
        .a     (a[gi]),
        .b     (b[gi]),
        .c_in  (carry[gi]),
        .sum   (sum[gi]),
        .c_out (carry[gi+1])
      );
    end
  endgenerate

  assign c_out = carry[N];

endmodule

// File: rtl/seq_adder_nbit.sv
// Multi-cycle WIDTH-bit add/subtract: CHUNK bits per cycle through one shared adder slice,
// carry held in a register between chunks, valid/ready handshake on both sides.
module seq_adder_nbit
  import seq_adder_nbit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Sum_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NCHUNK);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_adder_nbit: WIDTH must be >= 2 and divisible by CHUNK");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;

  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic [CHUNK-1:0]   chunk_sum;
  logic               chunk_cout;
  logic               last_chunk;

  assign chunk_a    = a_q[cnt_q*CHUNK +: CHUNK];
  assign chunk_b    = b_q[cnt_q*CHUNK +: CHUNK];
  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  adder_chunk #(.N(CHUNK)) u_chunk (
    .a     (chunk_a),
    .b     (chunk_b),
    .c_in  (carry_q),
    .sum   (chunk_sum),
    .c_out (chunk_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction folds into addition: A + ~B with carry-in 1.
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          cnt_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = sub ? ~B[WIDTH-1] : B[WIDTH-1];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[cnt_q*CHUNK +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
        if (last_chunk) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  // in_ready follows reset_n directly so it is low for the whole reset pulse.
  assign in_ready  = reset_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Sum_out   = {carry_q, res_q};
  assign overflow  = (state_q == S_DONE) && (a_msb_q == b_msb_q) && (res_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Directed and randomised checks of seq_adder_nbit at three parameter points.
module tb_seq_adder_nbit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Main instance: WIDTH=8, CHUNK=2
  logic       in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic       in_ready, out_valid, overflow;
  logic [8:0] Sum_out;

  seq_adder_nbit #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .Sum_out(Sum_out),
    .overflow(overflow)
  );

  // WIDTH=8, CHUNK=8
  logic       p1_in_valid = 1'b0, p1_sub = 1'b0, p1_out_ready = 1'b0;
  logic [7:0] p1_A = '0, p1_B = '0;
  logic       p1_in_ready, p1_out_valid, p1_overflow;
  logic [8:0] p1_Sum_out;

  seq_adder_nbit #(.WIDTH(8), .CHUNK(8)) dut_c8 (
    .clk(clk), .reset_n(reset_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready), .sub(p1_sub),
    .A(p1_A), .B(p1_B), .out_valid(p1_out_valid), .out_ready(p1_out_ready),
    .Sum_out(p1_Sum_out), .overflow(p1_overflow)
  );

  // WIDTH=16, CHUNK=4
  logic        p2_in_valid = 1'b0, p2_sub = 1'b0, p2_out_ready = 1'b0;
  logic [15:0] p2_A = '0, p2_B = '0;
  logic        p2_in_ready, p2_out_valid, p2_overflow;
  logic [16:0] p2_Sum_out;

  seq_adder_nbit #(.WIDTH(16), .CHUNK(4)) dut_w16 (
    .clk(clk), .reset_n(reset_n), .in_valid(p2_in_valid), .in_ready(p2_in_ready), .sub(p2_sub),
    .A(p2_A), .B(p2_B), .out_valid(p2_out_valid), .out_ready(p2_out_ready),
    .Sum_out(p2_Sum_out), .overflow(p2_overflow)
  );

  // Runs one operation on the main instance; returns result and accept-to-valid latency.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [8:0] sum, output logic ovf, output int lat);
    int w;
    w = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; A = a; B = b; sub = s;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    total++;
    if (w >= 20) begin
      bad++;
      $display("FAIL op8_accept in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b; sub = ~s;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    sum = Sum_out;
    ovf = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("op a=%h b=%h sub=%b -> Sum_out=%h overflow=%b latency=%0d", a, b, s, sum, ovf, lat);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++;
    if (Sum_out !== 9'h000) begin bad++; $display("FAIL reset_sum got=%h exp=000", Sum_out); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    $display("reset checked");
  endtask

  task automatic run_table(input string name, input logic [7:0] ta[3], input logic [7:0] tb[3],
                           input logic ts, input logic [8:0] te[3], input logic to[3]);
    logic [8:0] s;
    logic o;
    int lat;
    for (int i = 0; i < 3; i++) begin
      op8(ta[i], tb[i], ts, s, o, lat);
      total++;
      if (s !== te[i]) begin bad++; $display("FAIL %s_sum[%0d] got=%h exp=%h", name, i, s, te[i]); end
      total++;
      if (o !== to[i]) begin bad++; $display("FAIL %s_ovf[%0d] got=%b exp=%b", name, i, o, to[i]); end
      total++;
      if (lat != 4) begin bad++; $display("FAIL %s_latency[%0d] got=%0d exp=4", name, i, lat); end
    end
  endtask

  task automatic test_add();
    run_table("add", '{8'h03, 8'hFF, 8'h7F}, '{8'h01, 8'h01, 8'h01}, 1'b0,
              '{9'h004, 9'h100, 9'h080}, '{1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_sub();
    run_table("sub", '{8'h05, 8'h03, 8'h80}, '{8'h03, 8'h05, 8'h01}, 1'b1,
              '{9'h102, 9'h0FE, 9'h17F}, '{1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    in_valid = 1'b1; A = 8'h12; B = 8'h34; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
    total++;
    if (w != 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", w); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
      total++;
      if (Sum_out !== 9'h046) begin bad++; $display("FAIL bp_sum[%0d] got=%h exp=046", i, Sum_out); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_handoff_valid got=%b exp=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_handoff_ready got=%b exp=1", in_ready); end
    $display("backpressure held 5 cycles, Sum_out=%h", Sum_out);
  endtask

  task automatic test_early_out_ready();
    int w;
    out_ready = 1'b1;
    in_valid = 1'b1; A = 8'h20; B = 8'h22; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
    total++;
    if (w != 4) begin bad++; $display("FAIL early_rdy_latency got=%0d exp=4", w); end
    total++;
    if (Sum_out !== 9'h042) begin bad++; $display("FAIL early_rdy_sum got=%h exp=042", Sum_out); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL early_rdy_handoff got=%b exp=0", out_valid); end
    $display("out_ready held high through RUN, Sum_out=042 expected");
  endtask

  task automatic test_reset_mid();
    logic [8:0] s;
    logic o;
    int lat;
    in_valid = 1'b1; A = 8'h3C; B = 8'h0F; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    total++;
    if (Sum_out !== 9'h000) begin bad++; $display("FAIL midrst_sum got=%h exp=000", Sum_out); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b exp=1", in_ready); end
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_result got=%b exp=0", out_valid); end
    op8(8'h3C, 8'h0F, 1'b0, s, o, lat);
    total++;
    if (s !== 9'h04B) begin bad++; $display("FAIL midrst_fresh_sum got=%h exp=04B", s); end
    total++;
    if (lat != 4) begin bad++; $display("FAIL midrst_fresh_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_params();
    int w;
    p1_in_valid = 1'b1; p1_A = 8'hFF; p1_B = 8'hFF; p1_sub = 1'b0;
    total++;
    if (p1_in_ready !== 1'b1) begin bad++; $display("FAIL c8_in_ready got=%b exp=1", p1_in_ready); end
    @(posedge clk); #1;
    p1_in_valid = 1'b0;
    w = 0;
    while (!p1_out_valid && w < 40) begin @(posedge clk); #1; w++; end
    total++;
    if (w != 1) begin bad++; $display("FAIL c8_latency got=%0d exp=1", w); end
    total++;
    if (p1_Sum_out !== 9'h1FE) begin bad++; $display("FAIL c8_sum got=%h exp=1FE", p1_Sum_out); end
    total++;
    if (p1_overflow !== 1'b0) begin bad++; $display("FAIL c8_ovf got=%b exp=0", p1_overflow); end
    p1_out_ready = 1'b1;
    @(posedge clk); #1;
    p1_out_ready = 1'b0;
    $display("op W8C8 a=FF b=FF -> Sum_out=%h latency=%0d", p1_Sum_out, w);

    p2_in_valid = 1'b1; p2_A = 16'hFFFF; p2_B = 16'h0001; p2_sub = 1'b0;
    total++;
    if (p2_in_ready !== 1'b1) begin bad++; $display("FAIL w16_in_ready got=%b exp=1", p2_in_ready); end
    @(posedge clk); #1;
    p2_in_valid = 1'b0;
    w = 0;
    while (!p2_out_valid && w < 40) begin @(posedge clk); #1; w++; end
    total++;
    if (w != 4) begin bad++; $display("FAIL w16_latency got=%0d exp=4", w); end
    total++;
    if (p2_Sum_out !== 17'h10000) begin bad++; $display("FAIL w16_sum got=%h exp=10000", p2_Sum_out); end
    total++;
    if (p2_overflow !== 1'b0) begin bad++; $display("FAIL w16_ovf got=%b exp=0", p2_overflow); end
    p2_out_ready = 1'b1;
    @(posedge clk); #1;
    p2_out_ready = 1'b0;
    $display("op W16C4 a=FFFF b=0001 -> Sum_out=%h latency=%0d", p2_Sum_out, w);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic s;
    int u, sr, lat, w;
    logic [8:0] exp_sum;
    logic exp_ovf;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      in_valid = 1'b0; out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (s) begin
        u = int'(a) - int'(b);
        exp_sum = {(a >= b), 8'(u)};
        sr = int'($signed(a)) - int'($signed(b));
      end else begin
        u = int'(a) + int'(b);
        exp_sum = {(u > 255), 8'(u)};
        sr = int'($signed(a)) + int'($signed(b));
      end
      exp_ovf = (sr > 127) || (sr < -128);
      in_valid = 1'b1; A = a; B = b; sub = s;
      w = 0;
      while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
        out_ready = 1'($urandom);
        @(posedge clk); #1; lat++;
      end
      total++;
      if (Sum_out !== exp_sum || overflow !== exp_ovf || lat != 4) begin
        bad++;
        $display("FAIL rand[%0d] a=%h b=%h sub=%b got sum=%h ovf=%b lat=%0d exp sum=%h ovf=%b lat=4",
                 n, a, b, s, Sum_out, overflow, lat, exp_sum, exp_ovf);
      end
      $display("rand %0d a=%h b=%h sub=%b -> Sum_out=%h overflow=%b", n, a, b, s, Sum_out, overflow);
      // Fresh result is visible this cycle even if out_ready was drawn high; hand it off now.
      out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_handoff[%0d] got=%b exp=0", n, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_early_out_ready();
    test_reset_mid();
    test_params();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
